// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, default
// bus widths and a one-hot to index helper.
package mem_arb_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_RESP  = 2'd2;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = idx | 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker with lock override. A held lock wins
// only while its owner is still requesting; otherwise the first valid
// requester at or after rr_ptr_i (wrapping) is chosen.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  input  logic               lock_en_i,
  input  logic [IDX_W-1:0]   lock_owner_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  logic [2:0]     idx8_s;
  logic [IDX_W:0] scan_s;
  logic           found_s;

  // Pick the winner: lock owner first, else rotating scan from rr_ptr_i.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    scan_s  = '0;
    if (lock_en_i && valid_i[lock_owner_i]) begin
      grant_o[lock_owner_i] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_s = {1'b0, rr_ptr_i} + (IDX_W+1)'(k);
        if (scan_s >= (IDX_W+1)'(NUM_REQ)) begin
          scan_s = scan_s - (IDX_W+1)'(NUM_REQ);
        end else begin
          scan_s = scan_s;
        end
        if (!found_s && valid_i[scan_s[IDX_W-1:0]]) begin
          grant_o[scan_s[IDX_W-1:0]] = 1'b1;
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Encode the one-hot grant as an index.
  always_comb begin
    idx8_s    = onehot_to_idx(8'(grant_o));
    win_idx_o = idx8_s[IDX_W-1:0];
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one synchronous memory port among NUM_REQ requesters. Each access
// takes accept -> issue -> response; a new accept may overlap a response.
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = mem_arb_pkg::ADDR_W,
  parameter int DATA_W   = mem_arb_pkg::DATA_W,
  parameter int MAX_LOCK = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         memory_address,
  output logic [DATA_W-1:0]         memory_data_out,
  output logic                      memory_write_enable,
  input  logic [DATA_W-1:0]         memory_data_in
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  // Locking is allowed while the count of locked grants stays below this.
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              lock_en_q, lock_en_d;
  logic [IDX_W-1:0]  lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  win_q, win_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               arb_window_s;
  logic               accept_s;
  logic               lock_held_s;
  logic [CNT_W-1:0]   cnt_base_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid_i      (req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .lock_en_i    (lock_en_q),
    .lock_owner_i (lock_owner_q),
    .grant_o      (grant_s),
    .win_idx_o    (win_idx_s)
  );

  // Next-state logic: FSM, request capture, rotation pointer and lock count.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_en_d    = lock_en_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    win_d        = win_q;

    arb_window_s = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
    accept_s     = arb_window_s && (|grant_s);
    // A lock only counts as held while its owner keeps requesting.
    lock_held_s  = lock_en_q && req_valid[lock_owner_q];
    cnt_base_s   = lock_held_s ? lock_cnt_q : '0;

    case (state_q)
      ARB_IDLE:  state_d = accept_s ? ARB_ISSUE : ARB_IDLE;
      ARB_ISSUE: state_d = ARB_RESP;
      ARB_RESP:  state_d = accept_s ? ARB_ISSUE : ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase

    if (accept_s) begin
      addr_d  = req_addr[win_idx_s*ADDR_W +: ADDR_W];
      wdata_d = req_wdata[win_idx_s*DATA_W +: DATA_W];
      we_d    = req_we[win_idx_s];
      win_d   = win_idx_s;
      if (win_idx_s == IDX_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_idx_s + IDX_W'(1);
      end
      if (req_lock[win_idx_s] && (cnt_base_s < LOCK_LIMIT)) begin
        lock_en_d    = 1'b1;
        lock_owner_d = win_idx_s;
        lock_cnt_d   = cnt_base_s + CNT_W'(1);
      end else begin
        lock_en_d  = 1'b0;
        lock_cnt_d = '0;
      end
    end else if (arb_window_s && lock_en_q && !lock_held_s) begin
      lock_en_d  = 1'b0;
      lock_cnt_d = '0;
    end else begin
      lock_en_d = lock_en_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      lock_en_q    <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      win_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_en_q    <= lock_en_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      win_q        <= win_d;
    end
  end

  // Output decode: accept pulse, memory drive and one-hot response.
  always_comb begin
    memory_address      = addr_q;
    memory_data_out     = wdata_q;
    memory_write_enable = (state_q == ARB_ISSUE) && we_q;
    if (accept_s && !reset) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
    if ((state_q == ARB_RESP) && !reset) begin
      rsp_valid = NUM_REQ'(1) << win_q;
      rsp_rdata = we_q ? '0 : memory_data_in;
    end else begin
      rsp_valid = '0;
      rsp_rdata = '0;
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, all
// compared against a transaction-level reference model.
module tb_memory_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_lock, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, memory_data_out, memory_data_in;
  logic [AW-1:0]   memory_address;
  logic            memory_write_enable;

  memory_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_lock(req_lock),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .memory_address(memory_address), .memory_data_out(memory_data_out),
    .memory_write_enable(memory_write_enable), .memory_data_in(memory_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory emulation (stimulus side) and the model's own view of memory.
  logic [31:0] mem_emu [0:1023];
  logic [31:0] mem_ref [0:1023];

  always @(posedge clk) begin
    if (memory_write_enable) mem_emu[memory_address[11:2]] <= memory_data_out;
    memory_data_in <= mem_emu[memory_address[11:2]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester-side pending requests.
  bit          r_v [N];
  logic [31:0] r_addr [N];
  logic [31:0] r_wdata [N];
  bit          r_we [N];
  bit          r_lock [N];
  bit          auto_mode;

  // Reference model state.
  int          m_rr, m_owner, m_cnt;
  bit          m_lock_en;
  bit          m_iss_v, m_iss_we, m_rsp_v, m_rsp_we;
  int          m_iss_w, m_rsp_w;
  logic [31:0] m_iss_rd, m_rsp_rd, m_addr, m_wdata;

  int          last_win;
  logic [N-1:0] obs_ready, obs_rsp;
  logic [31:0] obs_rdata;
  logic        obs_we;
  logic [31:0] obs_addr;

  task automatic model_reset();
    m_rr = 0; m_owner = 0; m_cnt = 0; m_lock_en = 1'b0;
    m_iss_v = 1'b0; m_rsp_v = 1'b0; m_addr = '0; m_wdata = '0;
  endtask

  function automatic int model_pick();
    if (m_lock_en && r_v[m_owner]) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (r_v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic new_req(input int i);
    r_v[i]     = 1'b1;
    r_addr[i]  = 32'($urandom_range(0, 1023)) << 2;
    r_wdata[i] = $urandom;
    r_we[i]    = 1'($urandom_range(0, 1));
    r_lock[i]  = ($urandom_range(0, 3) == 0);
  endtask

  // One clock cycle: drive, compare with model, advance model, wait edge.
  task automatic step(input bit rst);
    int w;
    logic [N-1:0] e_ready, e_rsp;
    logic [31:0] e_rdata;
    reset = rst;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = r_v[i];
      req_we[i]    = r_we[i];
      req_lock[i]  = r_lock[i];
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
    end
    #1;
    obs_ready = req_ready; obs_rsp = rsp_valid; obs_rdata = rsp_rdata;
    obs_we = memory_write_enable; obs_addr = memory_address;
    w = -1; e_ready = '0; e_rsp = '0; e_rdata = '0;
    if (rst) begin
      check_val("rst_ready", obs_ready, '0);
      check_val("rst_rsp", obs_rsp, '0);
      model_reset();
    end else begin
      if (!m_iss_v) begin
        if (m_lock_en && !r_v[m_owner]) begin m_lock_en = 1'b0; m_cnt = 0; end
        w = model_pick();
      end
      if (w >= 0) e_ready[w] = 1'b1;
      if (m_rsp_v) begin
        e_rsp[m_rsp_w] = 1'b1;
        e_rdata = m_rsp_we ? 32'h0 : m_rsp_rd;
      end
      check_val("ready", obs_ready, e_ready);
      check_val("rsp_valid", obs_rsp, e_rsp);
      check_val("rsp_rdata", obs_rdata, e_rdata);
      check_val("mem_we", obs_we, m_iss_v && m_iss_we);
      check_val("mem_addr", obs_addr, m_addr);
      check_val("mem_wdata", memory_data_out, m_wdata);
      m_rsp_v = m_iss_v; m_rsp_w = m_iss_w; m_rsp_we = m_iss_we; m_rsp_rd = m_iss_rd;
      m_iss_v = (w >= 0);
      if (w >= 0) begin
        m_iss_w = w; m_iss_we = r_we[w]; m_addr = r_addr[w]; m_wdata = r_wdata[w];
        if (r_we[w]) begin
          mem_ref[r_addr[w][11:2]] = r_wdata[w];
          m_iss_rd = '0;
        end else begin
          m_iss_rd = mem_ref[r_addr[w][11:2]];
        end
        if (r_lock[w] && (m_cnt + 1 < ML)) begin
          m_lock_en = 1'b1; m_owner = w; m_cnt++;
        end else begin
          m_lock_en = 1'b0; m_cnt = 0;
        end
        m_rr = (w + 1) % N;
        r_v[w] = 1'b0;
      end
    end
    last_win = w;
    if (auto_mode) begin
      for (int i = 0; i < N; i++) if (!r_v[i] && $urandom_range(0, 1) == 1) new_req(i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      r_v[i] = 1'b0; r_we[i] = 1'b0; r_lock[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
    end
  endtask

  initial begin
    int wins [$];
    auto_mode = 1'b0;
    clear_reqs();
    for (int i = 0; i < 1024; i++) begin
      mem_emu[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      mem_ref[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    mem_emu[64] = 32'hDEAD_BEEF;
    mem_ref[64] = 32'hDEAD_BEEF;
    reset = 1'b1; req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;
    step(1'b1); step(1'b1);
    check_val("rst_addr", memory_address, 32'h0);
    check_val("rst_we", memory_write_enable, 1'b0);

    // Single read of 0x100.
    r_v[0] = 1'b1; r_addr[0] = 32'h100;
    step(1'b0); check_val("t1_ready", obs_ready, 2'b01);
    step(1'b0); check_val("t1_addr", obs_addr, 32'h100);
    step(1'b0); check_val("t1_rsp", obs_rsp, 2'b01); check_val("t1_rdata", obs_rdata, 32'hDEAD_BEEF);

    // Write then read back 0x40.
    r_v[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 32'h40; r_wdata[1] = 32'h1234_5678;
    step(1'b0); check_val("t2_ready", obs_ready, 2'b10); check_val("t2_we_T", obs_we, 1'b0);
    step(1'b0); check_val("t2_we_T1", obs_we, 1'b1); check_val("t2_wdata", memory_data_out, 32'h1234_5678);
    step(1'b0); check_val("t2_rsp", obs_rsp, 2'b10); check_val("t2_we_T2", obs_we, 1'b0);
    r_v[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h40;
    step(1'b0); step(1'b0); step(1'b0);
    check_val("t2_readback", obs_rdata, 32'h1234_5678);
    clear_reqs(); step(1'b0);

    // Continuous contention, no lock.
    step(1'b1);
    r_v[0] = 1'b1; r_v[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      if (k % 2 == 0) check_val("t3_grant", obs_ready, (k % 4 == 0) ? 2'b01 : 2'b10);
      else check_val("t3_idle", obs_ready, 2'b00);
      if (last_win >= 0) begin r_v[last_win] = 1'b1; r_addr[last_win] = 32'(k) << 4; end
    end

    // Bounded lock held by requester 0.
    clear_reqs(); step(1'b1);
    r_v[0] = 1'b1; r_v[1] = 1'b1; r_lock[0] = 1'b1;
    wins.delete();
    for (int k = 0; k < 12 && wins.size() < 5; k++) begin
      step(1'b0);
      if (last_win >= 0) begin wins.push_back(last_win); r_v[last_win] = 1'b1; end
    end
    check_val("t4_count", wins.size(), 5);
    for (int k = 0; k < 4 && k < wins.size(); k++) check_val("t4_locked", obs_ready === obs_ready ? wins[k] : 0, 0);
    if (wins.size() == 5) check_val("t4_break", wins[4], 1);
    check_val("t4_last_ready", obs_ready, 2'b10);

    // Lock released when owner stops requesting.
    clear_reqs(); step(1'b1);
    r_v[0] = 1'b1; r_lock[0] = 1'b1;
    step(1'b0); check_val("t5_accept", obs_ready, 2'b01);
    r_v[0] = 1'b0; r_v[1] = 1'b1;
    step(1'b0);
    step(1'b0); check_val("t5_release", obs_ready, 2'b10); check_val("t5_rsp", obs_rsp, 2'b01);
    clear_reqs(); step(1'b0); step(1'b0);

    // Reset during the issue cycle of a write.
    step(1'b1);
    r_v[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 32'h80; r_wdata[1] = 32'h0000_0055;
    step(1'b0); check_val("t6_accept", obs_ready, 2'b10);
    step(1'b1);
    r_v[0] = 1'b1; r_v[1] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 32'h84; r_we[1] = 1'b0;
    step(1'b0);
    check_val("t6_we", obs_we, 1'b0); check_val("t6_rsp", obs_rsp, 2'b00);
    check_val("t6_grant", obs_ready, 2'b01);
    clear_reqs(); step(1'b0); step(1'b0); step(1'b0);

    // Randomized traffic with occasional resets.
    step(1'b1);
    auto_mode = 1'b1;
    for (int k = 0; k < 800; k++) step($urandom_range(0, 99) == 0);
    auto_mode = 1'b0;
    clear_reqs(); step(1'b0); step(1'b0); step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
